object_scanner: RTL and testbench

OBJECT_SCANNER -- requirements
Module: object_scanner

---
 rtl/object_scanner_pkg.sv | 6 +
 rtl/object_scanner.sv | 97 +++++++++
 tb/tb_object_scanner.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/object_scanner_pkg.sv
// object_scanner_pkg: label and location widths shared by the labeling pipeline.
package object_scanner_pkg;
  localparam int LBL_WIDTH = 8;
  localparam int LOC_SIZE = 16;
  localparam int MAX_LABEL = 1 << LBL_WIDTH;
endpackage

// File: rtl/object_scanner.sv
// object_scanner: walks labels 1..last-1, reads their moments and streams records meeting min_area.
module object_scanner
  import object_scanner_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [LBL_WIDTH-1:0] num_labels,
  input  logic [LOC_SIZE-1:0]  min_area,
  output logic [LBL_WIDTH-1:0] obj_id,
  input  logic [LOC_SIZE-1:0]  obj_area,
  input  logic [LOC_SIZE-1:0]  obj_x,
  input  logic [LOC_SIZE-1:0]  obj_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LBL_WIDTH-1:0] out_id,
  output logic [LOC_SIZE-1:0]  out_area,
  output logic [LOC_SIZE-1:0]  out_x,
  output logic [LOC_SIZE-1:0]  out_y,
  output logic                 busy,
  output logic                 done,
  output logic [LBL_WIDTH-1:0] obj_count
);
  localparam int CW = $clog2(RD_LATENCY) + 1;
  localparam logic [LBL_WIDTH-1:0] ONE = LBL_WIDTH'(1);
  localparam logic [LBL_WIDTH-1:0] CNT_MAX = LBL_WIDTH'(MAX_LABEL - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);
  typedef enum logic [2:0] {IDLE, WAIT, EVAL, OUT, FIN} state_t;
  state_t r_state, w_next, w_fetch, w_step;
  logic [LBL_WIDTH-1:0] r_last;
  logic [CW-1:0] r_wait;
  logic w_hit, w_end, w_acc, w_adv;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // A single-edge readout needs no WAIT: EVAL directly follows the obj_id change.
  always_comb begin
    w_hit = obj_area != '0 && obj_area >= min_area;
    w_end = obj_id == r_last - ONE;
    w_acc = out_valid && out_ready;
    w_fetch = RD_LATENCY > 1 ? WAIT : EVAL;
    w_step = w_end ? FIN : w_fetch;
    w_adv = (r_state == EVAL && !w_hit) || (r_state == OUT && w_acc);
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !start ? IDLE : num_labels <= ONE ? FIN : w_fetch;
      WAIT:    w_next = r_wait == WAIT_LAST ? EVAL : WAIT;
      EVAL:    w_next = w_hit ? OUT : w_step;
      OUT:     w_next = w_acc ? w_step : OUT;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last    <= '0;
      r_wait    <= '0;
      obj_id    <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_area  <= '0;
      out_x     <= '0;
      out_y     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      obj_count <= '0;
    end else begin
      r_wait <= r_state == WAIT ? r_wait + CW'(1) : '0;
      done   <= r_state == FIN;
      if (r_state == IDLE && start) begin
        r_last    <= num_labels;
        obj_count <= '0;
        obj_id    <= ONE;
        busy      <= 1'b1;
      end
      if (r_state == EVAL) begin
        out_id    <= obj_id;
        out_area  <= obj_area;
        out_x     <= obj_x;
        out_y     <= obj_y;
        out_valid <= w_hit;
      end
      if (w_acc) begin
        out_valid <= 1'b0;
        obj_count <= obj_count == CNT_MAX ? obj_count : obj_count + ONE;
      end
      if (w_adv && !w_end) obj_id <= obj_id + ONE;
      if (r_state == FIN) begin
        busy   <= 1'b0;
        obj_id <= '0;
      end
    end
  end
endmodule

// File: tb/tb_object_scanner.sv
// tb_object_scanner: three scanners (read latency 1..3) against a label-table model with delayed readout.
module tb_object_scanner;
  import object_scanner_pkg::*;
  typedef struct packed {
    logic [LBL_WIDTH-1:0] id;
    logic [LOC_SIZE-1:0] a, x, y;
  } rec_t;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [LBL_WIDTH-1:0] num_labels = '0;
  logic [LOC_SIZE-1:0] min_area = '0;
  logic [LBL_WIDTH-1:0] obj_id [3], out_id [3], obj_count [3], d1 [3], d2 [3], rid [3];
  logic [LOC_SIZE-1:0] obj_area [3], obj_x [3], obj_y [3], out_area [3], out_x [3], out_y [3];
  logic out_valid [3], busy [3], done [3];
  logic [LOC_SIZE-1:0] m_area [MAX_LABEL], m_x [MAX_LABEL], m_y [MAX_LABEL];
  rec_t got [3][$];
  int dones [3] = '{0, 0, 0};
  int b_got [3], b_done [3];
  int checks = 0, errors = 0;
  logic [LBL_WIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    object_scanner #(.RD_LATENCY(g + 1)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .num_labels(num_labels), .min_area(min_area),
      .obj_id(obj_id[g]), .obj_area(obj_area[g]), .obj_x(obj_x[g]), .obj_y(obj_y[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready), .out_id(out_id[g]), .out_area(out_area[g]),
      .out_x(out_x[g]), .out_y(out_y[g]), .busy(busy[g]), .done(done[g]), .obj_count(obj_count[g])
    );
  end

  // Label table readout: scanner g sees the entry for the obj_id it drove g edges ago.
  always_comb begin
    for (int g = 0; g < 3; g++) begin
      rid[g] = g == 0 ? obj_id[g] : g == 1 ? d1[g] : d2[g];
      obj_area[g] = m_area[rid[g]];
      obj_x[g] = m_x[rid[g]];
      obj_y[g] = m_y[rid[g]];
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      d1[g] <= obj_id[g];
      d2[g] <= d1[g];
      if (out_valid[g] && out_ready) got[g].push_back({out_id[g], out_area[g], out_x[g], out_y[g]});
      if (done[g]) dones[g] <= dones[g] + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mem(input int i, input logic [LOC_SIZE-1:0] a);
    m_area[i] = a;
    m_x[i] = LOC_SIZE'($urandom);
    m_y[i] = LOC_SIZE'($urandom);
  endtask

  task automatic set_base();
    set_mem(1, 16'd5);
    set_mem(2, 16'd3);
    set_mem(3, 16'd9);
  endtask

  task automatic snap();
    for (int g = 0; g < 3; g++) begin
      b_got[g] = got[g].size();
      b_done[g] = dones[g];
    end
  endtask

  task automatic pulse_start(input logic [LBL_WIDTH-1:0] nl, input logic [LOC_SIZE-1:0] ma);
    @(negedge clk);
    num_labels = nl;
    min_area = ma;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic build_exp(input logic [LBL_WIDTH-1:0] nl, input logic [LOC_SIZE-1:0] ma);
    exp_q.delete();
    for (int i = 1; i < int'(nl); i++)
      if (m_area[i] != 0 && m_area[i] >= ma) exp_q.push_back(LBL_WIDTH'(i));
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    while (n < 4000 && !(dones[0] > b_done[0] && dones[1] > b_done[1] && dones[2] > b_done[2])) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n++;
    end
    out_ready = 1'b1;
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL wait_done: no done from every scanner within %0d cycles", n);
    end
    tick(3);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({out_valid[g], busy[g], done[g]} !== 3'b000) begin
        errors++;
        $display("FAIL reset lat%0d flags: valid/busy/done %b%b%b, expected 000", g + 1, out_valid[g], busy[g], done[g]);
      end
      checks++;
      if ({obj_id[g], obj_count[g], out_id[g]} !== '0) begin
        errors++;
        $display("FAIL reset lat%0d ids: obj_id %0d count %0d out_id %0d, expected 0", g + 1, obj_id[g], obj_count[g], out_id[g]);
      end
      checks++;
      if ({out_area[g], out_x[g], out_y[g]} !== '0) begin
        errors++;
        $display("FAIL reset lat%0d fields: %h %h %h, expected 0", g + 1, out_area[g], out_x[g], out_y[g]);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [LBL_WIDTH-1:0] nl;
    logic [LOC_SIZE-1:0] ma;
    rec_t r, e;
    for (int s = 0; s < 12; s++) begin
      if (s < 2) begin
        set_base();
        nl = 4;
        ma = s == 0 ? 16'd0 : 16'd5;
      end else if (s == 2) begin
        set_mem(1, 16'hF000);
        set_mem(2, 16'h7FFF);
        set_mem(3, 16'h0000);
        set_mem(4, 16'h8000);
        nl = 5;
        ma = 16'h8000;
      end else begin
        for (int i = 1; i < 16; i++) set_mem(i, $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom_range(1, 20)));
        nl = 8'($urandom_range(0, 15));
        ma = 16'($urandom_range(0, 20));
      end
      build_exp(nl, ma);
      snap();
      pulse_start(nl, ma);
      wait_done(s >= 3);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (got[g].size() - b_got[g] != exp_q.size()) begin
          errors++;
          $display("FAIL scan%0d lat%0d count: got %0d records, expected %0d", s, g + 1, got[g].size() - b_got[g], exp_q.size());
        end else begin
          for (int k = 0; k < exp_q.size(); k++) begin
            r = got[g][b_got[g] + k];
            e = '{id: exp_q[k], a: m_area[exp_q[k]], x: m_x[exp_q[k]], y: m_y[exp_q[k]]};
            checks++;
            if (r !== e) begin
              errors++;
              $display("FAIL scan%0d lat%0d rec%0d: got id %0d area %h x %h y %h, expected id %0d area %h x %h y %h",
                       s, g + 1, k, r.id, r.a, r.x, r.y, e.id, e.a, e.x, e.y);
            end
          end
        end
        checks++;
        if (obj_count[g] !== LBL_WIDTH'(exp_q.size())) begin
          errors++;
          $display("FAIL scan%0d lat%0d obj_count: got %0d, expected %0d", s, g + 1, obj_count[g], exp_q.size());
        end
        checks++;
        if (dones[g] - b_done[g] != 1 || busy[g] !== 1'b0 || obj_id[g] !== '0) begin
          errors++;
          $display("FAIL scan%0d lat%0d end: dones %0d busy %b obj_id %0d, expected 1 0 0", s, g + 1, dones[g] - b_done[g], busy[g], obj_id[g]);
        end
      end
    end
  endtask

  task automatic test_single();
    for (int nl = 0; nl < 2; nl++) begin
      snap();
      pulse_start(LBL_WIDTH'(nl), 16'd0);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (busy[g] !== 1'b1 || done[g] !== 1'b0) begin
          errors++;
          $display("FAIL single%0d lat%0d cycle1: busy %b done %b, expected 1 0", nl, g + 1, busy[g], done[g]);
        end
      end
      tick(1);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (busy[g] !== 1'b0 || done[g] !== 1'b1) begin
          errors++;
          $display("FAIL single%0d lat%0d cycle2: busy %b done %b, expected 0 1", nl, g + 1, busy[g], done[g]);
        end
      end
      tick(1);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (done[g] !== 1'b0 || dones[g] - b_done[g] != 1 || got[g].size() != b_got[g] || obj_count[g] !== '0) begin
          errors++;
          $display("FAIL single%0d lat%0d after: done %b pulses %0d records %0d count %0d, expected 0 1 0 0",
                   nl, g + 1, done[g], dones[g] - b_done[g], got[g].size() - b_got[g], obj_count[g]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rec_t s_rec [3];
    logic [LBL_WIDTH-1:0] s_id [3];
    int n = 0;
    set_base();
    snap();
    out_ready = 1'b0;
    pulse_start(8'd4, 16'd0);
    while (n < 50 && !(out_valid[0] && out_valid[1] && out_valid[2])) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL backpressure: out_valid not raised by all scanners within %0d cycles", n);
    end
    for (int g = 0; g < 3; g++) begin
      s_rec[g] = {out_id[g], out_area[g], out_x[g], out_y[g]};
      s_id[g] = obj_id[g];
      checks++;
      if (s_rec[g].id !== 8'd1 || s_rec[g].a !== 16'd5) begin
        errors++;
        $display("FAIL backpressure lat%0d first: id %0d area %0d, expected 1 5", g + 1, s_rec[g].id, s_rec[g].a);
      end
    end
    repeat (10) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (out_valid[g] !== 1'b1 || {out_id[g], out_area[g], out_x[g], out_y[g]} !== s_rec[g] || obj_id[g] !== s_id[g]) begin
          errors++;
          $display("FAIL backpressure lat%0d hold: valid %b id %0d area %h obj_id %0d, expected 1 %0d %h %0d",
                   g + 1, out_valid[g], out_id[g], out_area[g], obj_id[g], s_rec[g].id, s_rec[g].a, s_id[g]);
        end
      end
    end
    wait_done(1'b0);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (got[g].size() - b_got[g] != 3 || obj_count[g] !== 8'd3) begin
        errors++;
        $display("FAIL backpressure lat%0d total: records %0d count %0d, expected 3 3", g + 1, got[g].size() - b_got[g], obj_count[g]);
      end else begin
        checks++;
        if (got[g][b_got[g]].id !== 8'd1 || got[g][b_got[g] + 1].id !== 8'd2) begin
          errors++;
          $display("FAIL backpressure lat%0d order: ids %0d %0d, expected 1 2", g + 1, got[g][b_got[g]].id, got[g][b_got[g] + 1].id);
        end
      end
    end
  endtask

  task automatic test_restart_ignored();
    for (int i = 1; i < 8; i++) set_mem(i, 16'd7);
    snap();
    pulse_start(8'd4, 16'd0);
    tick(2);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (busy[g] !== 1'b1) begin
        errors++;
        $display("FAIL restart lat%0d busy: got %b, expected 1", g + 1, busy[g]);
      end
    end
    pulse_start(8'd7, 16'd0);
    wait_done(1'b0);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (got[g].size() - b_got[g] != 3 || obj_count[g] !== 8'd3 || dones[g] - b_done[g] != 1) begin
        errors++;
        $display("FAIL restart lat%0d: records %0d count %0d dones %0d, expected 3 3 1",
                 g + 1, got[g].size() - b_got[g], obj_count[g], dones[g] - b_done[g]);
      end
    end
  endtask

  task automatic test_reset_midscan();
    int pre_done [3];
    int n = 0;
    set_base();
    snap();
    pulse_start(8'd4, 16'd0);
    while (n < 100 && !(out_valid[1] && out_id[1] == 8'd2)) begin
      out_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL midscan: lat2 never reached OUT of id 2 within %0d cycles", n);
    end
    for (int g = 0; g < 3; g++) pre_done[g] = dones[g];
    #2 reset_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({out_valid[g], busy[g], done[g], obj_id[g], obj_count[g], out_id[g], out_area[g], out_x[g], out_y[g]} !== '0) begin
        errors++;
        $display("FAIL midscan lat%0d async reset: valid %b busy %b obj_id %0d count %0d out_id %0d area %h, expected all 0",
                 g + 1, out_valid[g], busy[g], obj_id[g], obj_count[g], out_id[g], out_area[g]);
      end
    end
    tick(2);
    snap();
    reset_n = 1'b1;
    out_ready = 1'b1;
    num_labels = 8'd4;
    min_area = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (busy[g] !== 1'b1 || dones[g] != pre_done[g]) begin
        errors++;
        $display("FAIL midscan lat%0d restart: busy %b stray dones %0d, expected 1 0", g + 1, busy[g], dones[g] - pre_done[g]);
      end
    end
    wait_done(1'b0);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (got[g].size() - b_got[g] != 3 || dones[g] - b_done[g] != 1) begin
        errors++;
        $display("FAIL midscan lat%0d rescan: records %0d dones %0d, expected 3 1", g + 1, got[g].size() - b_got[g], dones[g] - b_done[g]);
      end else begin
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (got[g][b_got[g] + k].id !== LBL_WIDTH'(k + 1)) begin
            errors++;
            $display("FAIL midscan lat%0d rec%0d: id %0d, expected %0d", g + 1, k, got[g][b_got[g] + k].id, k + 1);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MAX_LABEL; i++) set_mem(i, 16'h0777);
    test_reset();
    test_scan();
    test_single();
    test_backpressure();
    test_restart_ignored();
    test_reset_midscan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
